// File: rtl/irq_ctrl.sv
// Interrupt latch/controller: edge-captures source lines into pending bits, masks them,
// and presents the lowest-index enabled source as a single req/ack interrupt.
module irq_ctrl #(
  parameter int NSRC = 4,
  localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NSRC-1:0] i_src,
  input  logic            i_mask_we,
  input  logic [NSRC-1:0] i_mask_wdata,
  input  logic            i_clr,
  input  logic [NSRC-1:0] i_clr_bits,
  input  logic            i_ack,
  output logic [NSRC-1:0] o_mask,
  output logic [NSRC-1:0] o_pending,
  output logic            o_irq,
  output logic [IDW-1:0]  o_irq_id
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]      state;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] enabled;
  logic [NSRC-1:0] ack_vec;
  logic            ack_fire;
  logic [IDW-1:0]  irq_id;

  function automatic logic [IDW-1:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = IDW'(i);
    end
    return r;
  endfunction

  assign rise     = i_src & ~src_q;
  assign enabled  = pending & mask;
  assign ack_fire = (state == ST_REQ) && i_ack;

  // A new edge always wins over either form of clear in the same cycle.
  always_comb begin
    ack_vec     = '0;
    pending_nxt = pending;
    for (int i = 0; i < NSRC; i++) begin
      ack_vec[i] = ack_fire && (irq_id == IDW'(i));
      if (rise[i])
        pending_nxt[i] = 1'b1;
      else if (ack_vec[i] || (i_clr && i_clr_bits[i]))
        pending_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
      state   <= ST_IDLE;
      irq_id  <= '0;
    end else begin
      src_q   <= i_src;
      pending <= pending_nxt;
      if (i_mask_we) mask <= i_mask_wdata;
      case (state)
        ST_IDLE: begin
          if (|enabled) begin
            irq_id <= lowest_idx(enabled);
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_ack) state <= ST_GAP;
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_mask    = mask;
  assign o_pending = pending;
  assign o_irq     = (state == ST_REQ);
  assign o_irq_id  = irq_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       clr = 1'b0;
  logic [3:0] clr_bits = '0;
  logic       ack = 1'b0;
  logic [3:0] mask_o;
  logic [3:0] pend_o;
  logic       irq_o;
  logic [1:0] id_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit [3:0] m_src, m_pend, m_mask;
  bit       m_req, m_gap;
  int       m_id;

  irq_ctrl #(.NSRC(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_src(src), .i_mask_we(mask_we),
    .i_mask_wdata(mask_wdata), .i_clr(clr), .i_clr_bits(clr_bits), .i_ack(ack),
    .o_mask(mask_o), .o_pending(pend_o), .o_irq(irq_o), .o_irq_id(id_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [3:0] rise, np, en;
    bit       ackd;
    if (rst) begin
      m_src = '0; m_pend = '0; m_mask = '0; m_req = 0; m_gap = 0; m_id = 0;
      return;
    end
    rise = src & ~m_src;
    en   = m_pend & m_mask;
    ackd = m_req && ack;
    np   = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) np[i] = 1'b1;
      else if (ackd && i == m_id) np[i] = 1'b0;
      else if (clr && clr_bits[i]) np[i] = 1'b0;
    end
    if (mask_we) m_mask = mask_wdata;
    if (m_req) begin
      if (ack) begin m_req = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (en != 0) begin
      for (int i = 3; i >= 0; i--) if (en[i]) m_id = i;
      m_req = 1;
    end
    m_src  = src;
    m_pend = np;
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic mwe,
                      input logic [3:0] mw, input logic c, input logic [3:0] cb,
                      input logic a);
    rst = r; src = s; mask_we = mwe; mask_wdata = mw; clr = c; clr_bits = cb; ack = a;
    @(posedge clk);
    model_edge();
    #1;
    check("model_pending", 32'(pend_o), 32'(m_pend));
    check("model_mask",    32'(mask_o), 32'(m_mask));
    check("model_irq",     32'(irq_o),  32'(m_req));
    check("model_id",      32'(id_o),   32'(m_id));
  endtask

  initial begin
    // reset state
    step(1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    step(1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    check("rst_irq", 32'(irq_o), 0);
    check("rst_pend", 32'(pend_o), 0);
    check("rst_id", 32'(id_o), 0);

    // single source latency
    step(0, 4'h0, 1, 4'h1, 0, 4'h0, 0);
    step(0, 4'h1, 0, 4'h0, 0, 4'h0, 0);
    check("t1_pend_k", 32'(pend_o), 32'h1);
    check("t1_irq_k", 32'(irq_o), 0);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    check("t1_irq_k1", 32'(irq_o), 1);
    check("t1_id_k1", 32'(id_o), 0);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    check("t1_gap_irq", 32'(irq_o), 0);
    check("t1_ack_pend", 32'(pend_o), 0);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);

    // simultaneous rises: lowest index first, then the other after GAP
    step(0, 4'h0, 1, 4'hF, 0, 4'h0, 0);
    step(0, 4'h6, 0, 4'h0, 0, 4'h0, 0);
    step(0, 4'h6, 0, 4'h0, 0, 4'h0, 0);
    check("t2_id_first", 32'(id_o), 1);
    step(0, 4'h6, 0, 4'h0, 0, 4'h0, 1);
    check("t2_gap", 32'(irq_o), 0);
    check("t2_pend", 32'(pend_o), 32'h4);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    check("t2_idle", 32'(irq_o), 0);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    check("t2_irq2", 32'(irq_o), 1);
    check("t2_id2", 32'(id_o), 2);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);

    // masked source becomes visible when the mask is written
    step(0, 4'h0, 1, 4'h0, 0, 4'h0, 0);
    step(0, 4'h8, 0, 4'h0, 0, 4'h0, 0);
    step(0, 4'h8, 0, 4'h0, 0, 4'h0, 0);
    check("t3_no_irq", 32'(irq_o), 0);
    check("t3_pend", 32'(pend_o), 32'h8);
    step(0, 4'h8, 1, 4'h8, 0, 4'h0, 0);
    check("t3_wr_irq", 32'(irq_o), 0);
    step(0, 4'h8, 0, 4'h0, 0, 4'h0, 0);
    check("t3_irq", 32'(irq_o), 1);
    check("t3_id", 32'(id_o), 3);
    check("t3_pend_held", 32'(pend_o), 32'h8);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);

    // new rise on the acked source survives the ack
    step(0, 4'h0, 1, 4'h1, 0, 4'h0, 0);
    step(0, 4'h1, 0, 4'h0, 0, 4'h0, 0);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    check("t4_irq", 32'(irq_o), 1);
    step(0, 4'h1, 0, 4'h0, 0, 4'h0, 1);
    check("t4_pend_kept", 32'(pend_o), 32'h1);
    check("t4_gap", 32'(irq_o), 0);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    step(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    check("t4_reirq", 32'(irq_o), 1);
    check("t4_reid", 32'(id_o), 0);

    // reset mid-REQ clears everything
    step(1, 4'h2, 0, 4'h0, 0, 4'h0, 0);
    check("t6_irq", 32'(irq_o), 0);
    check("t6_pend", 32'(pend_o), 0);
    check("t6_mask", 32'(mask_o), 0);

    // level held through reset release: one event, clear, no re-trigger
    step(0, 4'h2, 0, 4'h0, 0, 4'h0, 0);
    check("t5_event", 32'(pend_o), 32'h2);
    step(0, 4'h2, 0, 4'h0, 1, 4'h2, 0);
    check("t5_clr", 32'(pend_o), 0);
    step(0, 4'h2, 0, 4'h0, 0, 4'h0, 1);
    check("t5_no_retrig", 32'(pend_o), 0);
    check("t6_ack_idle", 32'(irq_o), 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 5) == 0),
           4'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom),
           ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
